// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit with memory handshake, illegal-op trap and retire counter
module mc_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             InstrDone,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetiredCount
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11, TRAP = 4'd12
  } state_t;
  state_t state_q, state_d;
  logic done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stall, funct_ok, ir_write, pc_write, branch, mem_write, reg_write;
  logic [2:0] funct_alu;
  assign stall = MEM_HANDSHAKE && !MemReady;
  assign funct_ok = Funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign funct_alu = Funct == 6'b100010 ? 3'b110 :
                     Funct == 6'b100100 ? 3'b000 :
                     Funct == 6'b100101 ? 3'b001 :
                     Funct == 6'b101010 ? 3'b111 : 3'b010;
  always_comb begin
    state_d = state_q;
    MemRead = 1'b0;
    IorD = 1'b0;
    ir_write = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    reg_write = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUControl = 3'b010;
    PCSrc = 2'b00;
    pc_write = 1'b0;
    branch = 1'b0;
    mem_write = 1'b0;
    IllegalOp = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ir_write = !stall;
        pc_write = !stall;
        state_d = stall ? FETCH : DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        state_d = (Opcode == 6'b100011 || Opcode == 6'b101011) ? MEMADR :
                  Opcode == 6'b000000 ? EXEC :
                  Opcode == 6'b000100 ? BRANCH :
                  Opcode == 6'b001000 ? ADDIEX :
                  Opcode == 6'b000010 ? JUMP : TRAP;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = Opcode == 6'b101011 ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        state_d = stall ? MEMRD : MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        reg_write = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        IorD = 1'b1;
        mem_write = !stall;
        state_d = stall ? MEMWR : FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUControl = funct_alu;
        state_d = funct_ok ? ALUWB : TRAP;
      end
      ALUWB: begin
        RegDst = 1'b1;
        reg_write = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUControl = 3'b110;
        PCSrc = 2'b01;
        branch = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        PCSrc = 2'b10;
        pc_write = 1'b1;
        state_d = FETCH;
      end
      default: IllegalOp = 1'b1;
    endcase
    // enables must stay low for the whole time Reset is held, even in FETCH
    MemWrite = mem_write && !Reset;
    IRWrite = ir_write && !Reset;
    RegWrite = reg_write && !Reset;
    PCEn = (pc_write || (branch && Zero)) && !Reset;
    done_d = (state_q inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP}) || (state_q == MEMWR && !stall);
    cnt_d = cnt_q + CNT_W'(done_d);
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
    end
  end
  assign State = state_q;
  assign InstrDone = done_q;
  assign RetiredCount = cnt_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven instruction walk plus reset, stall, trap and wrap sequences
module tb_mc_control_fsm;
  logic Clk = 1'b0, Reset = 1'b1, Zero = 1'b0, MemReady = 1'b1;
  logic [5:0] Opcode = 6'd0, Funct = 6'd0;
  logic MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, InstrDone, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State, RetiredCount;
  logic MemRead_0, MemWrite_0, IorD_0, IRWrite_0, RegDst_0, MemtoReg_0, RegWrite_0, ALUSrcA_0, PCEn_0, InstrDone_0, IllegalOp_0;
  logic [1:0] ALUSrcB_0, PCSrc_0;
  logic [2:0] ALUControl_0;
  logic [3:0] State_0;
  logic [31:0] RetiredCount_0;
  logic [17:0] ctl;
  int errors = 0, checks = 0;
  always #5 Clk = ~Clk;
  mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp), .State(State), .RetiredCount(RetiredCount));
  mc_control_fsm #(.MEM_HANDSHAKE(1'b0), .CNT_W(32)) dut0 (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemRead(MemRead_0), .MemWrite(MemWrite_0), .IorD(IorD_0), .IRWrite(IRWrite_0), .RegDst(RegDst_0),
    .MemtoReg(MemtoReg_0), .RegWrite(RegWrite_0), .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0),
    .ALUControl(ALUControl_0), .PCSrc(PCSrc_0), .PCEn(PCEn_0), .InstrDone(InstrDone_0),
    .IllegalOp(IllegalOp_0), .State(State_0), .RetiredCount(RetiredCount_0));
  assign ctl = {MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCEn, InstrDone, IllegalOp};
  // {MemRead,MemWrite,IorD,IRWrite}_{RegDst,MemtoReg,RegWrite,ALUSrcA}_ALUSrcB_ALUControl_PCSrc_{PCEn,InstrDone,IllegalOp}
  localparam logic [17:0] F0 = 18'b1001_0000_01_010_00_100;
  localparam logic [17:0] F1 = 18'b1001_0000_01_010_00_110;
  localparam logic [17:0] DE = 18'b0000_0000_11_010_00_000;
  localparam logic [17:0] MA = 18'b0000_0001_10_010_00_000;
  localparam logic [17:0] MR = 18'b1010_0000_00_010_00_000;
  localparam logic [17:0] MB = 18'b0000_0110_00_010_00_000;
  localparam logic [17:0] MW = 18'b0110_0000_00_010_00_000;
  localparam logic [17:0] AW = 18'b0000_0010_00_010_00_000;
  localparam logic [17:0] B1 = 18'b0000_0001_00_110_01_100;
  localparam logic [17:0] B0 = 18'b0000_0001_00_110_01_000;
  localparam logic [17:0] EA = 18'b0000_0001_00_010_00_000;
  localparam logic [17:0] RW = 18'b0000_1010_00_010_00_000;
  localparam logic [17:0] JP = 18'b0000_0000_00_010_10_100;
  localparam logic [17:0] TR = 18'b0000_0000_00_010_00_001;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    logic rdy;
    logic [3:0] st;
    logic [17:0] ctl;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
  initial begin
    int done_at, pulses;
    tbl.push_back('{LW, 6'd0, 1'b1, 1'b1, 4'd0, F0});
    tbl.push_back('{LW, 6'd0, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{LW, 6'd0, 1'b1, 1'b1, 4'd2, MA});
    tbl.push_back('{LW, 6'd0, 1'b1, 1'b1, 4'd3, MR});
    tbl.push_back('{LW, 6'd0, 1'b1, 1'b1, 4'd4, MB});
    tbl.push_back('{SW, 6'd0, 1'b1, 1'b1, 4'd0, F1});
    tbl.push_back('{SW, 6'd0, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{SW, 6'd0, 1'b1, 1'b1, 4'd2, MA});
    tbl.push_back('{SW, 6'd0, 1'b1, 1'b1, 4'd5, MW});
    tbl.push_back('{ADDI, 6'd0, 1'b1, 1'b1, 4'd0, F1});
    tbl.push_back('{ADDI, 6'd0, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{ADDI, 6'd0, 1'b1, 1'b1, 4'd9, MA});
    tbl.push_back('{ADDI, 6'd0, 1'b1, 1'b1, 4'd10, AW});
    tbl.push_back('{BEQ, 6'd0, 1'b1, 1'b1, 4'd0, F1});
    tbl.push_back('{BEQ, 6'd0, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{BEQ, 6'd0, 1'b1, 1'b1, 4'd8, B1});
    tbl.push_back('{BEQ, 6'd0, 1'b0, 1'b1, 4'd0, F1});
    tbl.push_back('{BEQ, 6'd0, 1'b0, 1'b1, 4'd1, DE});
    tbl.push_back('{BEQ, 6'd0, 1'b0, 1'b1, 4'd8, B0});
    tbl.push_back('{RT, 6'b100000, 1'b1, 1'b1, 4'd0, F1});
    tbl.push_back('{RT, 6'b100000, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{RT, 6'b100000, 1'b1, 1'b1, 4'd6, EA});
    tbl.push_back('{RT, 6'b100000, 1'b1, 1'b1, 4'd7, RW});
    tbl.push_back('{JMP, 6'd0, 1'b1, 1'b1, 4'd0, F1});
    tbl.push_back('{JMP, 6'd0, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{JMP, 6'd0, 1'b1, 1'b1, 4'd11, JP});
    tbl.push_back('{BAD, 6'd0, 1'b1, 1'b1, 4'd0, F1});
    tbl.push_back('{BAD, 6'd0, 1'b1, 1'b1, 4'd1, DE});
    tbl.push_back('{BAD, 6'd0, 1'b1, 1'b1, 4'd12, TR});
    tbl.push_back('{BAD, 6'd0, 1'b1, 1'b1, 4'd12, TR});
    do_reset();
    foreach (tbl[i]) begin
      Opcode = tbl[i].op;
      Funct = tbl[i].fn;
      Zero = tbl[i].z;
      MemReady = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_state", i), 32'(State), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
      @(negedge Clk);
    end
    chk("tbl_retired", 32'(RetiredCount), 32'd7);
    for (int i = 0; i < 100; i++) begin
      #1;
      chk("trap_illegal", 32'(IllegalOp), 32'd1);
      chk("trap_count", 32'(RetiredCount), 32'd7);
      @(negedge Clk);
    end
    Opcode = SW;
    MemReady = 1'b1;
    Reset = 1'b1;
    #1;
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_pcen", 32'(PCEn), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("sw_state0", 32'(State), 32'd0);
    @(negedge Clk);
    #1;
    chk("sw_state1", 32'(State), 32'd1);
    @(negedge Clk);
    #1;
    chk("sw_state2", 32'(State), 32'd2);
    @(negedge Clk);
    #1;
    chk("sw_state5", 32'(State), 32'd5);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    Reset = 1'b1;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_pcen", 32'(PCEn), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("abort_rel_state", 32'(State), 32'd0);
    chk("abort_rel_count", 32'(RetiredCount), 32'd0);
    chk("abort_rel_done", 32'(InstrDone), 32'd0);
    @(negedge Clk);
    #1;
    chk("abort_fresh_decode", 32'(State), 32'd1);
    do_reset();
    Opcode = LW;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      MemReady = (i >= 3);
      #1;
      if (i < 3) begin
        chk("stall_state", 32'(State), 32'd0);
        chk("stall_irwrite", 32'(IRWrite), 32'd0);
        chk("stall_memread", 32'(MemRead), 32'd1);
      end
      if (i == 3) chk("stall_release_irwrite", 32'(IRWrite), 32'd1);
      if (InstrDone) begin
        done_at = i;
        break;
      end
      @(negedge Clk);
    end
    chk("stall_lw_cycles", 32'(done_at), 32'd8);
    @(negedge Clk);
    do_reset();
    MemReady = 1'b0;
    Opcode = RT;
    Funct = 6'b101010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("slt_state%0d", i), 32'(State_0), (i == 2) ? 32'd6 : (i == 3) ? 32'd7 : (i == 4) ? 32'd0 : 32'(i));
      if (i == 2) chk("slt_aluctl", 32'(ALUControl_0), 32'b111);
      if (i == 3) chk("slt_regwrite", 32'(RegWrite_0), 32'd1);
      if (i == 4) begin
        chk("slt_count", RetiredCount_0, 32'd1);
        chk("slt_done", 32'(InstrDone_0), 32'd1);
      end
      @(negedge Clk);
    end
    do_reset();
    Opcode = JMP;
    MemReady = 1'b1;
    pulses = 0;
    for (int i = 0; i <= 48; i++) begin
      #1;
      pulses += int'(InstrDone);
      if (i == 24) chk("wrap_mid_count", 32'(RetiredCount), 32'd8);
      @(negedge Clk);
    end
    chk("wrap_pulses", 32'(pulses), 32'd16);
    chk("wrap_count", 32'(RetiredCount), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
